phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Parametrised successor to the fixed 3-phase bus clock generator.
- Produces PHASES one-hot, one-cycle phase strobes that sequence the ctrl, read and write transfers on the shared read/data/write buses.
- Adds behaviour the fixed generator lacks: per-channel wait-state insertion with a timeout, single-step mode, cycle-boundary stop, and a completed-cycle counter.
- Sits at the top level between the system clock and all bus agents (control, ALU, RAM, ROM, bridge).

Parameters:
- PHASES, 3, number of phases per bus cycle (>=2); strobe k drives phase k.
- CHANNELS, 4, number of bus agents able to request wait states.
- WAIT_PHASE, 1, index of the phase that can be held off by wait_req (must be < PHASES).
- WAIT_MAX, 15, maximum stall cycles before a forced advance (>=1).
- COUNT_WIDTH, 16, width of cycle_count.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled at cycle boundaries.
- run_mode  in  1  1 = free run, 0 = single-step.
- step  in  1  single-step request; rising edge detected internally.
- wait_req  in  CHANNELS  per-agent wait-state request.
- clear_timeout  in  1  synchronous clear of timeout and timeout_ch.
- out  out  PHASES  one-hot phase strobes, registered.
- phase  out  $clog2(PHASES)  index of the next phase to issue.
- cycle_count  out  COUNT_WIDTH  completed bus cycles, wraps.
- running  out  1  high in RUN or STALL.
- stalled  out  1  high in STALL.
- timeout  out  1  sticky wait-timeout flag.
- timeout_ch  out  $clog2(CHANNELS)  lowest-index channel requesting wait at the timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - out=0, phase=0, cycle_count=0, running=0, stalled=0, timeout=0, timeout_ch=0.
  - Wait counter = 0; step edge register = 0.
- States: IDLE, RUN, STALL, HOLD.
- IDLE:
  - out=0.
  - enable=1 and run_mode=1 -> RUN; out[0]=1 in the following cycle.
  - enable=1 and run_mode=0 -> HOLD.
- RUN:
  - Each clk issues strobe out[phase]=1 for exactly one cycle, then phase <= (phase+1) mod PHASES.
  - Before issuing WAIT_PHASE: if |wait_req=1, go to STALL instead. out=0, phase holds, wait counter=1.
- STALL:
  - out=0, stalled=1.
  - wait_req all 0 -> issue out[WAIT_PHASE] that cycle, return to RUN, clear counter.
  - Counter == WAIT_MAX while still requested -> forced issue of out[WAIT_PHASE]. timeout <= 1; timeout_ch <= lowest set bit of wait_req.
  - A stall therefore inserts 1..WAIT_MAX idle cycles; a strobe never exceeds 1 cycle.
- Cycle boundary (issue of out[PHASES-1]):
  - cycle_count += 1, wrapping from 2^COUNT_WIDTH-1 to 0.
  - Then: enable=0 -> IDLE; run_mode=0 -> HOLD; else continue with out[0].
  - enable and run_mode changes mid-cycle never truncate a cycle; they take effect only here.
- HOLD:
  - out=0.
  - A rising edge on step (step=1, previous step=0) starts exactly one full cycle in RUN; that cycle ends in HOLD again if run_mode is still 0.
  - run_mode=1 -> RUN. enable=0 -> IDLE.
  - step held high produces one cycle only.
- timeout:
  - Sticky; cleared only by reset or clear_timeout=1.
  - A new timeout in the same cycle as clear_timeout wins (flag stays 1, timeout_ch updated).
- wait_req outside WAIT_PHASE is ignored.
- Reset mid-cycle or mid-stall aborts immediately to the reset values. The partial cycle is not counted.
- Invariant: $countones(out) <= 1 at all times.

Test Plan:
- Free run (PHASES=3), reset released, enable=1, run_mode=1, wait_req=0 -> out sequence 001,010,100 repeating; cycle_count=10 after 30 strobe cycles.
- wait_req[2]=1 for 4 cycles entering phase 1 -> out=000 for 4 cycles with stalled=1, then 010; timeout stays 0.
- wait_req[3:2]=11 held indefinitely, WAIT_MAX=15 -> 15 stall cycles, forced 010, timeout=1, timeout_ch=2; clear_timeout pulse -> timeout=0.
- run_mode=0, three step pulses, step held high 10 cycles each time -> exactly 3 full cycles, cycle_count=3, HOLD with out=000 between them.
- enable dropped while out=010 -> 100 still issued, then IDLE; cycle_count incremented once.
- reset asserted asynchronously during STALL -> all outputs 0 without waiting for clk; after release with COUNT_WIDTH=4, 17 cycles -> cycle_count wraps to 1.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control, wait-request and phase-strobe bundle of the phase sequencer
`timescale 1ns/1ps

interface phase_sequencer_if #(
   parameter int PHASES      = 3,
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 16
);
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                   enable;
   logic                   run_mode;
   logic                   step;
   logic [CHANNELS-1:0]    wait_req;
   logic                   clear_timeout;
   logic [PHASES-1:0]      out;
   logic [PW-1:0]          phase;
   logic [COUNT_WIDTH-1:0] cycle_count;
   logic                   running;
   logic                   stalled;
   logic                   timeout;
   logic [CW-1:0]          timeout_ch;

   // master: the sequencer that issues strobes; slave: the bus agents and controller
   modport master (
      input  enable, run_mode, step, wait_req, clear_timeout,
      output out, phase, cycle_count, running, stalled, timeout, timeout_ch
   );

   modport slave (
      output enable, run_mode, step, wait_req, clear_timeout,
      input  out, phase, cycle_count, running, stalled, timeout, timeout_ch
   );
endinterface

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot bus phase strobe generator with wait states, single-step and cycle counter
`timescale 1ns/1ps

module phase_sequencer #(
   parameter int PHASES      = 3,
   parameter int CHANNELS    = 4,
   parameter int WAIT_PHASE  = 1,
   parameter int WAIT_MAX    = 15,
   parameter int COUNT_WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   phase_sequencer_if.master bus
);
   localparam int PW  = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WCW = $clog2(WAIT_MAX + 1);

   localparam logic [PW-1:0]  WAIT_IDX = PW'(WAIT_PHASE);
   localparam logic [PW-1:0]  LAST_IDX = PW'(PHASES - 1);
   localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

   typedef enum logic [1:0] {IDLE, RUN, STALL, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic [PHASES-1:0]      out_q, out_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                   running_q, running_d;
   logic                   stalled_q, stalled_d;
   logic                   timeout_q, timeout_d;
   logic [CW-1:0]          timeout_ch_q, timeout_ch_d;
   logic                   step_q, step_d;

   logic                   issue;
   logic                   step_rise;
   logic                   any_wait;
   logic [CW-1:0]          lowest_ch;

   assign step_rise = bus.step & ~step_q;
   assign any_wait  = |bus.wait_req;

   always_comb begin
      lowest_ch = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (bus.wait_req[i]) lowest_ch = CW'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      out_d        = '0;
      count_d      = count_q;
      wait_cnt_d   = wait_cnt_q;
      step_d       = bus.step;
      timeout_d    = bus.clear_timeout ? 1'b0 : timeout_q;
      timeout_ch_d = bus.clear_timeout ? '0 : timeout_ch_q;
      issue        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.enable) state_d = bus.run_mode ? RUN : HOLD;
         end
         HOLD: begin
            if (!bus.enable)                       state_d = IDLE;
            else if (bus.run_mode || step_rise)    state_d = RUN;
         end
         RUN: begin
            if (phase_q == WAIT_IDX && any_wait) begin
               state_d    = STALL;
               wait_cnt_d = WCW'(1);
            end else begin
               issue = 1'b1;
            end
         end
         STALL: begin
            if (!any_wait) begin
               issue = 1'b1;
            end else if (wait_cnt_q == WAIT_LIM) begin
               // forced advance; a same-cycle clear_timeout loses to the new timeout
               issue        = 1'b1;
               timeout_d    = 1'b1;
               timeout_ch_d = lowest_ch;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         out_d      = PHASES'(1) << phase_q;
         wait_cnt_d = '0;
         if (phase_q == LAST_IDX) begin
            // cycle boundary: the only point where enable and run_mode take effect
            phase_d = '0;
            count_d = count_q + COUNT_WIDTH'(1);
            if (!bus.enable)        state_d = IDLE;
            else if (!bus.run_mode) state_d = HOLD;
            else                    state_d = RUN;
         end else begin
            phase_d = phase_q + PW'(1);
            state_d = RUN;
         end
      end

      running_d = (state_d == RUN) || (state_d == STALL);
      stalled_d = (state_d == STALL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         phase_q      <= '0;
         out_q        <= '0;
         count_q      <= '0;
         wait_cnt_q   <= '0;
         running_q    <= 1'b0;
         stalled_q    <= 1'b0;
         timeout_q    <= 1'b0;
         timeout_ch_q <= '0;
         step_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         out_q        <= out_d;
         count_q      <= count_d;
         wait_cnt_q   <= wait_cnt_d;
         running_q    <= running_d;
         stalled_q    <= stalled_d;
         timeout_q    <= timeout_d;
         timeout_ch_q <= timeout_ch_d;
         step_q       <= step_d;
      end
   end

   assign bus.out         = out_q;
   assign bus.phase       = phase_q;
   assign bus.cycle_count = count_q;
   assign bus.running     = running_q;
   assign bus.stalled     = stalled_q;
   assign bus.timeout     = timeout_q;
   assign bus.timeout_ch  = timeout_ch_q;
endmodule
